shift_counter_cfg: RTL
======================

Name: shift_counter_cfg

Overview:
- Parametrised ring/Johnson shift counter. It generalises the fixed 5-bit ring/Johnson counter to any width.
- Adds the following over the 5-bit counter:
  - shift-direction control
  - count enable
  - parallel load
  - illegal-state self-correction, flagged by an error pulse
  - a wrap pulse marking each completed cycle
- Intended as a reusable sequencer/one-hot phase generator for the counter family.

Parameters:
- WIDTH, 5, counter width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  step enable; when 0 the counter holds.
- js_rg  input  1  mode select: 1 = Johnson (twisted ring), 0 = ring.
- dir  input  1  shift direction: 0 = shift toward MSB, 1 = shift toward LSB.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value captured on load.
- count  output  WIDTH  registered counter state.
- wrap  output  1  registered one-cycle pulse: a normal step just produced the home state.
- err  output  1  registered one-cycle pulse: a self-correction step just occurred.

Behaviour:
- Reset:
  - While rst=1, asynchronously: count = {WIDTH-1 zeros, 1} (e.g. 00001), wrap=0, err=0.
  - This reset value is legal in both modes.
- Priority each rising edge (rst released): load > en > hold.
- Load:
  - count <= load_val verbatim; no legality check.
  - wrap <= 0, err <= 0.
- Hold (en=0, load=0): count unchanged; wrap <= 0, err <= 0.
- Legality of current count:
  - ring mode: legal iff exactly one bit set.
  - Johnson mode: legal iff count contains at most one position i (0..WIDTH-2) with count[i] != count[i+1]. This covers all-zeros, all-ones, and contiguous runs of ones anchored at LSB or MSB.
- Enabled step (en=1, load=0), count legal for current js_rg:
  - feedback bit fb:
    - dir=0: fb = count[WIDTH-1] (ring) or ~count[WIDTH-1] (Johnson).
    - dir=1: fb = count[0] (ring) or ~count[0] (Johnson).
  - next state:
    - dir=0: count <= {count[WIDTH-2:0], fb}.
    - dir=1: count <= {fb, count[WIDTH-1:1]}.
  - wrap <= 1 iff new count equals home (ring home = 0..01; Johnson home = all zeros); err <= 0.
- Enabled step with count illegal (self-correction):
  - count <= home of the current mode.
  - err <= 1, wrap <= 0.
  - Correction takes exactly one step; normal stepping resumes on the next enabled edge.
- Periods: ring = WIDTH steps; Johnson = 2*WIDTH steps; wrap fires once per period in either direction.
- Mode change (js_rg toggled):
  - Takes effect on the next enabled edge using the current count.
  - If count is illegal in the new mode, that edge is a correction step.
- dir change: takes effect on the next enabled edge; no correction needed, since legal sets are direction-independent.
- Simultaneous load and en: load wins, count = load_val, no pulses.
- Reset mid-operation: count returns to 0..01 immediately, without waiting for clk; pulses cleared.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan (WIDTH=5):
1. Ring, dir=0: assert rst -> count=00001, wrap=0, err=0. Release, js_rg=0, dir=0, en=1 -> 00010, 00100, 01000, 10000, 00001, with wrap=1 only in the cycle count=00001.
2. Johnson, dir=0: load 00000, then js_rg=1, dir=0, en=1 -> 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000, 00000, with wrap=1 only on the 10th step; err stays 0.
3. Ring, dir=1: from reset, js_rg=0, dir=1, en=1 -> 10000, 01000, 00100, 00010, 00001 (wrap); then en=0 for 3 cycles -> count holds at 00001, wrap=0.
4. Mode switch: Johnson at 00111, set js_rg=0, en=1 -> next count=00001, err=1 for one cycle, wrap=0. Following step -> 00010, err=0.
5. Illegal load: load 10101 with en=1, js_rg=1 -> count=10101, no pulses. Next enabled edge -> count=00000, err=1. Next -> 00001.
6. Async reset: assert rst midway between edges during a Johnson run at 11100 -> count=00001 before the next clk edge, wrap=err=0. Release -> stepping resumes from 00001.

Source files
------------

// File: rtl/shift_counter_cfg.sv
// rtl/shift_counter_cfg.sv - parametrised ring/Johnson shift counter with load, direction and self-correction
module shift_counter_cfg #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             js_rg,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] RING_HOME    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] JOHNSON_HOME = '0;

  logic [WIDTH-1:0] home;
  logic             legal;
  logic             fb;
  logic [WIDTH-1:0] step_val;

  // Ring states are one-hot: exactly one bit set.
  function automatic logic ring_legal(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) n++;
    end
    return (n == 1);
  endfunction

  // Johnson states have at most one boundary between adjacent differing bits.
  function automatic logic johnson_legal(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (v[i] != v[i+1]) n++;
    end
    return (n <= 1);
  endfunction

  // Mode-dependent home, legality and the candidate next state of a normal step.
  always_comb begin
    home  = js_rg ? JOHNSON_HOME : RING_HOME;
    legal = js_rg ? johnson_legal(count) : ring_legal(count);
    if (dir) begin
      fb = js_rg ? ~count[0] : count[0];
    end else begin
      fb = js_rg ? ~count[WIDTH-1] : count[WIDTH-1];
    end
    step_val = dir ? {fb, count[WIDTH-1:1]} : {count[WIDTH-2:0], fb};
  end

  // State and pulse registers: load beats enable; an illegal state is forced home in one step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RING_HOME;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (en) begin
      if (legal) begin
        count <= step_val;
        wrap  <= (step_val == home);
        err   <= 1'b0;
      end else begin
        count <= home;
        wrap  <= 1'b0;
        err   <= 1'b1;
      end
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
    end
  end

endmodule
